// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared types and constants for the two-requester ALU arbiter
package alu_arbiter_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam logic [2:0] ILLEGAL_OP = 3'b111;

   // Ownership record that rides alongside each op while the ALU computes it
   typedef struct packed {
      logic vld;
      logic id;
      logic err;
   } tag_t;
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - two-way round-robin grant with a one-bit priority pointer
module rr_arb2 (
   input  logic       clk_p_i,
   input  logic       reset_n_i,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);
   logic ptr_q;
   logic ptr_d;

   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
         else                gnt_o = req_i;
      end
      // Priority flips to the other requester only after a grant is taken
      ptr_d = ptr_q;
      if (gnt_o[0])      ptr_d = 1'b1;
      else if (gnt_o[1]) ptr_d = 1'b0;
   end

   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) ptr_q <= 1'b0;
      else            ptr_q <= ptr_d;
   end
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one pipelined ALU between two requesters, returning tagged in-order results
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int DW  = 8,
   parameter int LAT = 2
) (
   input  logic            clk_p_i,
   input  logic            reset_n_i,
   input  logic            req0_valid_i,
   output logic            req0_ready_o,
   input  logic [2:0]      req0_inst_i,
   input  logic [DW-1:0]   req0_a_i,
   input  logic [DW-1:0]   req0_b_i,
   input  logic            req1_valid_i,
   output logic            req1_ready_o,
   input  logic [2:0]      req1_inst_i,
   input  logic [DW-1:0]   req1_a_i,
   input  logic [DW-1:0]   req1_b_i,
   input  logic            hold_i,
   output logic [2:0]      alu_inst_o,
   output logic [DW-1:0]   alu_a_o,
   output logic [DW-1:0]   alu_b_o,
   input  logic [2*DW-1:0] alu_data_i,
   output logic            rsp0_valid_o,
   output logic            rsp1_valid_o,
   output logic [2*DW-1:0] rsp_data_o,
   output logic            rsp_err_o,
   output logic            busy_o
);
   state_e          state_q, state_d;
   tag_t            tag_q [LAT+1];
   logic [1:0]      gnt;
   logic            grant_en, accept, acc_id, acc_err, in_flight_d, busy;
   logic [2:0]      acc_inst;
   logic [DW-1:0]   acc_a, acc_b;
   logic [2:0]      alu_inst_q;
   logic [DW-1:0]   alu_a_q, alu_b_q;
   logic            rsp0_q, rsp1_q, rsp_err_q;
   logic [2*DW-1:0] rsp_data_q;

   assign grant_en = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && !hold_i;

   rr_arb2 u_arb (
      .clk_p_i   (clk_p_i),
      .reset_n_i (reset_n_i),
      .req_i     ({req1_valid_i, req0_valid_i}),
      .en_i      (grant_en),
      .gnt_o     (gnt)
   );

   assign req0_ready_o = gnt[0];
   assign req1_ready_o = gnt[1];
   assign accept       = |gnt;
   assign acc_id       = gnt[1];
   assign acc_inst     = gnt[1] ? req1_inst_i : req0_inst_i;
   assign acc_a        = gnt[1] ? req1_a_i    : req0_a_i;
   assign acc_b        = gnt[1] ? req1_b_i    : req0_b_i;
   assign acc_err      = (acc_inst == ILLEGAL_OP);

   // in_flight_d: will any stage still hold an op after this edge
   always_comb begin
      busy        = 1'b0;
      in_flight_d = accept;
      for (int i = 0; i <= LAT; i++) begin
         busy = busy | tag_q[i].vld;
         if (i < LAT) in_flight_d = in_flight_d | tag_q[i].vld;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (accept) state_d = ST_RUN;
         ST_RUN: begin
            if (hold_i && in_flight_d) state_d = ST_DRAIN;
            else if (!in_flight_d)     state_d = ST_IDLE;
         end
         ST_DRAIN: begin
            if (!in_flight_d)  state_d = ST_IDLE;
            else if (!hold_i)  state_d = ST_RUN;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i <= LAT; i++) tag_q[i] <= '0;
         alu_inst_q <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         rsp0_q     <= 1'b0;
         rsp1_q     <= 1'b0;
         rsp_err_q  <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         tag_q[0] <= {accept, acc_id & accept, acc_err & accept};
         for (int i = 1; i <= LAT; i++) tag_q[i] <= tag_q[i-1];
         // Illegal ops never reach the ALU; the bus keeps its previous command
         if (accept && !acc_err) begin
            alu_inst_q <= acc_inst;
            alu_a_q    <= acc_a;
            alu_b_q    <= acc_b;
         end
         rsp0_q     <= tag_q[LAT].vld & !tag_q[LAT].id;
         rsp1_q     <= tag_q[LAT].vld &  tag_q[LAT].id;
         rsp_err_q  <= tag_q[LAT].vld &  tag_q[LAT].err;
         rsp_data_q <= (tag_q[LAT].vld && !tag_q[LAT].err) ? alu_data_i : '0;
      end
   end

   assign alu_inst_o   = alu_inst_q;
   assign alu_a_o      = alu_a_q;
   assign alu_b_o      = alu_b_q;
   assign rsp0_valid_o = rsp0_q;
   assign rsp1_valid_o = rsp1_q;
   assign rsp_err_o    = rsp_err_q;
   assign rsp_data_o   = rsp_data_q;
   assign busy_o       = busy;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and random checks of alu_arbiter against an acceptance-history model
module tb_alu_arbiter;
   localparam int DW  = 8;
   localparam int LAT = 2;
   localparam int NE  = 4096;

   logic            clk = 1'b0;
   logic            reset_n_i;
   logic            req0_valid_i, req1_valid_i, hold_i;
   logic            req0_ready_o, req1_ready_o;
   logic [2:0]      req0_inst_i, req1_inst_i, alu_inst_o;
   logic [DW-1:0]   req0_a_i, req0_b_i, req1_a_i, req1_b_i, alu_a_o, alu_b_o;
   logic [2*DW-1:0] alu_data_i, rsp_data_o;
   logic            rsp0_valid_o, rsp1_valid_o, rsp_err_o, busy_o;

   always #5 clk = ~clk;

   alu_arbiter #(.DW(DW), .LAT(LAT)) dut (
      .clk_p_i(clk), .reset_n_i(reset_n_i),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_inst_i(req0_inst_i),
      .req0_a_i(req0_a_i), .req0_b_i(req0_b_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_inst_i(req1_inst_i),
      .req1_a_i(req1_a_i), .req1_b_i(req1_b_i),
      .hold_i(hold_i), .alu_inst_o(alu_inst_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
      .alu_data_i(alu_data_i), .rsp0_valid_o(rsp0_valid_o), .rsp1_valid_o(rsp1_valid_o),
      .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int edge_n = 0;
   int ptr, st;
   logic            exp_v [NE];
   logic            exp_id [NE];
   logic            exp_err [NE];
   logic [2*DW-1:0] exp_d [NE];
   logic            acc_at [NE];
   logic [2:0]      last_inst;
   logic [DW-1:0]   last_a, last_b;
   logic [2:0]      p_inst [LAT+1];
   logic [DW-1:0]   p_a [LAT+1];
   logic [DW-1:0]   p_b [LAT+1];

   function automatic logic [2*DW-1:0] alu_f(logic [2:0] i, logic [DW-1:0] a, logic [DW-1:0] b);
      logic [2*DW-1:0] xa, xb;
      xa = {{DW{1'b0}}, a};
      xb = {{DW{1'b0}}, b};
      case (i)
         3'd0:    return xa + xb;
         3'd1:    return xa - xb;
         3'd2:    return xa * xb;
         3'd3:    return xa & xb;
         3'd4:    return xa | xb;
         3'd5:    return xa ^ xb;
         3'd6:    return {a, b};
         default: return '0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, expv, edge_n);
      end
   endtask

   task automatic clear_model();
      for (int k = 0; k < NE; k++) begin
         exp_v[k] = 1'b0; exp_id[k] = 1'b0; exp_err[k] = 1'b0; exp_d[k] = '0; acc_at[k] = 1'b0;
      end
      for (int j = 0; j <= LAT; j++) begin
         p_inst[j] = '0; p_a[j] = '0; p_b[j] = '0;
      end
      ptr = 0; st = 0;
      last_inst = '0; last_a = '0; last_b = '0;
      alu_data_i = '0;
   endtask

   // One clock: entered just after a negedge with inputs already driven
   task automatic cycle();
      logic en, g0, g1, acc, inflight, err;
      logic [2:0] ci;
      logic [DW-1:0] ca, cb;
      int due;
      #1;
      en = (st != 2) && !hold_i;
      g0 = en && req0_valid_i && (!req1_valid_i || ptr == 0);
      g1 = en && req1_valid_i && (!req0_valid_i || ptr == 1);
      check("ready0", req0_ready_o, g0);
      check("ready1", req1_ready_o, g1);
      @(posedge clk);
      edge_n++;
      acc = g0 || g1;
      if (acc) begin
         ci  = g1 ? req1_inst_i : req0_inst_i;
         ca  = g1 ? req1_a_i : req0_a_i;
         cb  = g1 ? req1_b_i : req0_b_i;
         err = (ci == 3'b111);
         due = edge_n + LAT + 1;
         exp_v[due]   = 1'b1;
         exp_id[due]  = g1;
         exp_err[due] = err;
         exp_d[due]   = err ? '0 : alu_f(ci, ca, cb);
         acc_at[edge_n] = 1'b1;
         ptr = g0 ? 1 : 0;
         if (!err) begin
            last_inst = ci; last_a = ca; last_b = cb;
         end
      end
      inflight = 1'b0;
      for (int k = edge_n - LAT; k <= edge_n; k++)
         if (k >= 0 && acc_at[k]) inflight = 1'b1;
      case (st)
         0: if (acc) st = 1;
         1: if (hold_i && inflight) st = 2; else if (!inflight) st = 0;
         default: if (!inflight) st = 0; else if (!hold_i) st = 1;
      endcase
      #1;
      check("alu_inst", alu_inst_o, last_inst);
      check("alu_a", alu_a_o, last_a);
      check("alu_b", alu_b_o, last_b);
      check("rsp0_valid", rsp0_valid_o, exp_v[edge_n] && !exp_id[edge_n]);
      check("rsp1_valid", rsp1_valid_o, exp_v[edge_n] && exp_id[edge_n]);
      check("rsp_err", rsp_err_o, exp_v[edge_n] && exp_err[edge_n]);
      check("rsp_data", rsp_data_o, exp_v[edge_n] ? exp_d[edge_n] : '0);
      check("busy", busy_o, inflight);
      @(negedge clk);
      // Behavioural ALU: result of the command seen LAT cycles earlier
      for (int j = LAT; j > 0; j--) begin
         p_inst[j] = p_inst[j-1]; p_a[j] = p_a[j-1]; p_b[j] = p_b[j-1];
      end
      p_inst[0] = alu_inst_o; p_a[0] = alu_a_o; p_b[0] = alu_b_o;
      alu_data_i = alu_f(p_inst[LAT], p_a[LAT], p_b[LAT]);
   endtask

   task automatic idle(input int n);
      req0_valid_i = 1'b0; req1_valid_i = 1'b0; hold_i = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      reset_n_i = 1'b0;
      req0_valid_i = 1'b0; req1_valid_i = 1'b0; hold_i = 1'b0;
      @(posedge clk);
      edge_n++;
      #1;
      check("rst_alu_inst", alu_inst_o, 3'd0);
      check("rst_alu_a", alu_a_o, '0);
      check("rst_alu_b", alu_b_o, '0);
      check("rst_rsp", {rsp0_valid_o, rsp1_valid_o, rsp_err_o}, 3'b000);
      check("rst_rsp_data", rsp_data_o, '0);
      check("rst_busy", busy_o, 1'b0);
      @(negedge clk);
      clear_model();
      reset_n_i = 1'b1;
   endtask

   task automatic rand_ops();
      req0_inst_i = 3'($urandom_range(0, 6)); req0_a_i = DW'($urandom); req0_b_i = DW'($urandom);
      req1_inst_i = 3'($urandom_range(0, 6)); req1_a_i = DW'($urandom); req1_b_i = DW'($urandom);
   endtask

   initial begin
      req0_inst_i = '0; req0_a_i = '0; req0_b_i = '0;
      req1_inst_i = '0; req1_a_i = '0; req1_b_i = '0;
      clear_model();
      do_reset();

      // single legal op: 5 + 3
      req0_valid_i = 1'b1; req0_inst_i = 3'd0; req0_a_i = 8'h05; req0_b_i = 8'h03;
      cycle();
      idle(5);

      // contention: both valid for four cycles
      rand_ops();
      req0_valid_i = 1'b1; req1_valid_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         rand_ops();
      end
      idle(5);

      // illegal opcode from requester 1
      req1_valid_i = 1'b1; req1_inst_i = 3'b111; req1_a_i = 8'hAA; req1_b_i = 8'h55;
      cycle();
      idle(5);

      // two ops in flight, then hold while both still request
      rand_ops();
      req0_valid_i = 1'b1;
      cycle();
      req0_valid_i = 1'b0; req1_valid_i = 1'b1;
      cycle();
      req0_valid_i = 1'b1; hold_i = 1'b1;
      for (int i = 0; i < 6; i++) cycle();
      idle(3);

      // reset one cycle after acceptance drops the op
      rand_ops();
      req1_valid_i = 1'b1;
      cycle();
      req1_valid_i = 1'b0;
      cycle();
      do_reset();
      idle(5);
      rand_ops();
      req0_valid_i = 1'b1; req1_valid_i = 1'b1;
      cycle();
      idle(5);

      // random traffic including illegal ops and hold
      for (int i = 0; i < 500; i++) begin
         req0_valid_i = 1'($urandom_range(0, 1));
         req1_valid_i = 1'($urandom_range(0, 1));
         hold_i       = ($urandom_range(0, 4) == 0);
         req0_inst_i  = 3'($urandom_range(0, 7)); req0_a_i = DW'($urandom); req0_b_i = DW'($urandom);
         req1_inst_i  = 3'($urandom_range(0, 7)); req1_a_i = DW'($urandom); req1_b_i = DW'($urandom);
         cycle();
      end
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DW, 8, operand width; result width is 2*DW.
REQ-002 Parameter: LAT, 2, downstream ALU latency in cycles from alu_*_o presentation to alu_data_i valid; legal range 1..4.
REQ-003 clk_p_i  input  1  single clock, rising edge.
REQ-004 reset_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 reqN_valid_i  input  1  requester N (N=0,1) has a command.
REQ-006 reqN_ready_o  output  1  command N accepted this cycle.
REQ-007 reqN_inst_i  input  3  opcode for requester N.
REQ-008 reqN_a_i, reqN_b_i  input  DW each  operands for requester N.
REQ-009 hold_i  input  1  stop new grants; in-flight ops drain.
REQ-010 alu_inst_o, alu_a_o, alu_b_o  output  3/DW/DW  registered command to shared ALU.
REQ-011 alu_data_i  input  2*DW  ALU result.
REQ-012 rspN_valid_o  output  1  one-cycle pulse: result for requester N.
REQ-013 rsp_data_o  output  2*DW  result data, qualified by either rsp valid.
REQ-014 rsp_err_o  output  1  result is for an illegal opcode.
REQ-015 busy_o  output  1  any op in flight.

Function
REQ-016 At most one command SHALL be accepted per cycle; acceptance = reqN_valid_i & reqN_ready_o at a rising edge.
REQ-017 reqN_ready_o SHALL be combinational: high only for the granted requester, only when reqN_valid_i is high and the FSM is in IDLE or RUN with hold_i low.
REQ-018 Arbitration SHALL be round-robin: priority pointer resets to 0; after an acceptance the pointer moves to the other requester; without acceptance it does not move.
REQ-019 A lone valid requester SHALL be granted regardless of pointer.
REQ-020 An accepted command at edge T SHALL appear on alu_*_o throughout cycle T+1; in idle cycles alu_*_o hold their last value.
REQ-021 Opcode 3'b111 is illegal: accepted normally, not driven to alu_inst_o (alu_*_o unchanged), flagged with rsp_err_o=1 and rsp_data_o=0.
REQ-022 Each acceptance SHALL produce exactly one registered response: rspN_valid_o for the accepting requester high during cycle T+LAT+2, rsp_data_o = alu_data_i sampled at end of cycle T+LAT+1.
REQ-023 Responses SHALL return in acceptance order; a tag shift pipeline (valid, requester id, err) of depth LAT+1 SHALL track ownership; back-to-back acceptances yield back-to-back responses.
REQ-024 FSM states: IDLE (pipeline empty), RUN (ops in flight, hold_i low), DRAIN (hold_i high, ops in flight).
REQ-025 Transitions: IDLE->RUN on acceptance; RUN->IDLE when pipeline empties with no acceptance; RUN->DRAIN when hold_i rises with ops in flight; DRAIN->IDLE when pipeline empties; DRAIN->RUN when hold_i falls with ops still in flight; IDLE with hold_i high stays IDLE.
REQ-026 busy_o SHALL be high whenever any tag pipeline stage is valid.
REQ-027 Simultaneous response and acceptance in the same cycle SHALL both take effect without stall.
REQ-028 When rsp valids are low, rsp_data_o and rsp_err_o SHALL be 0.

Reset
REQ-029 On reset_n_i low: FSM=IDLE, pointer=0, tag pipeline cleared, alu_*_o=0, rsp valids/data/err=0, busy_o=0.
REQ-030 Reset mid-operation SHALL drop all in-flight ops; no response pulses SHALL follow for them.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the ILLEGAL_OP constant (3'b111) and the tag record type.
REQ-032 The round-robin grant logic SHALL be one sub-module, rr_arb2.

Verification
REQ-033 Single op: req0 inst=0 a=8'h05 b=8'h03 accepted at edge 0, alu_data_i=16'h0008 driven LAT cycles after presentation -> rsp0_valid_o pulse in cycle 4, rsp_data_o=16'h0008.
REQ-034 Contention: both valid continuously for 4 cycles -> grants 0,1,0,1; responses in the same order, back-to-back.
REQ-035 Illegal op: req1 inst=3'b111 -> alu_*_o unchanged, rsp1_valid_o in cycle 4 with rsp_err_o=1, rsp_data_o=0.
REQ-036 Hold: two ops in flight, hold_i high -> FSM DRAIN, readies low, both responses delivered, FSM IDLE, busy_o low.
REQ-037 Reset mid-op: reset_n_i pulsed low one cycle after acceptance -> no rsp pulse, all outputs 0, pointer 0.
